// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: bundles the RAM read port and the outbound beat stream
// of ram_stream_reader. master = the reader, slave = RAM + stream consumer.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // RAM port
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  // Beat stream
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output ram_en, ram_we, ram_addr, ram_din,
    input  ram_dout,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-only initiator for one port of behav_dual_port_ram.
// Streams length words starting at base_addr (wrapping at the top of the RAM)
// as valid/ready beats with a last marker. Reads are credit-gated so that the
// FIFO occupancy plus the one read in flight never exceeds FIFO_DEPTH, which
// absorbs the 1-cycle RAM latency and any downstream backpressure.
// Optional feature macro: RAM_STREAM_READER_PERF_EN adds a saturating
// stall_cycles counter (cycles with m_valid && !m_ready).
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  ram_stream_reader_if.master   bus
`ifdef RAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  ram_en_q, ram_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic                  m_valid_s;
  logic                  m_last_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W:0]        occ_s;

  // Circular pointer advance for a FIFO whose depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid_s = (fifo_count_q != '0);
  assign m_last_s  = m_valid_s && (beat_cnt_q == LEN_W'(1));
  assign push_s    = inflight_q;
  assign pop_s     = m_valid_s && bus.m_ready;

  // Transfer FSM next state: accepts start in IDLE, tracks issue/beat counts.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = ST_RUN;
            addr_d      = base_addr;
            issue_cnt_d = length;
            beat_cnt_d  = length;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ram_en_q) begin
          issue_cnt_d = issue_cnt_q - LEN_W'(1);
          addr_d      = addr_q + ADDR_WIDTH'(1);
        end else begin
          issue_cnt_d = issue_cnt_q;
          addr_d      = addr_q;
        end
        if (pop_s) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (m_last_s) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
          state_d    = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and the credit check that decides next cycle's read.
  always_comb begin
    fifo_count_d = fifo_count_q;
    occ_s        = '0;
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    // The read issued this cycle is next cycle's in-flight word.
    inflight_d = ram_en_q;
    occ_s      = {1'b0, fifo_count_d} + {{CNT_W{1'b0}}, inflight_d};
    ram_en_d   = (state_d == ST_RUN) && (issue_cnt_d != '0) &&
                 (occ_s < (CNT_W + 1)'(FIFO_DEPTH));
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FINISH);
  end

  // Control, counter and registered-output state; reset aborts and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_cnt_q  <= issue_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      ram_en_q     <= ram_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage: capture RAM data the cycle after a read was issued.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= bus.ram_dout;
    end
  end

`ifdef RAM_STREAM_READER_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter next value: clear on accepted start, saturate at all-ones.
  always_comb begin
    if (start && (state_q == ST_IDLE)) begin
      stall_d = 32'd0;
    end else if (m_valid_s && !bus.m_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = '0;
  assign bus.m_valid  = m_valid_s;
  // Gated so the bus reads zero whenever no beat is offered.
  assign bus.m_data   = m_valid_s ? fifo_mem[rd_ptr_q] : '0;
  assign bus.m_last   = m_last_s;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader with a
// behavioural 1-cycle-latency RAM preloaded with mem[i] = i + 0x100.
module tb_ram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
`ifdef RAM_STREAM_READER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
`ifdef RAM_STREAM_READER_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM read port, 1-cycle latency.
  always @(posedge clk) begin
    if (bus.ram_en === 1'b1) bus.ram_dout <= mem[bus.ram_addr];
  end

  function automatic logic [DW-1:0] exp_word(input int a);
    return 32'h100 + 32'(a & ((1 << AW) - 1));
  endfunction

  // Runs one transfer; scoreboards addresses and beats, checks credit and stall hold.
  task automatic run_transfer(input int base, input int len, input int ready_pct,
                              input int abort_after, input bit poke_start,
                              output int first_k, output int last_k,
                              output int done_k, output int stalls);
    logic [DW-1:0] exp_q[$];
    int            addr_q[$];
    int            k, issued, hs, bound, a;
    bit            fin, aborted, prev_stall, el;
    logic [DW-1:0] held_data, ed;
    logic          held_last;
    first_k = -1; last_k = -1; done_k = -1; stalls = 0;
    k = 0; issued = 0; hs = 0; fin = 1'b0; aborted = 1'b0; prev_stall = 1'b0;
    held_data = '0; held_last = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(exp_word(base + i));
      addr_q.push_back((base + i) & ((1 << AW) - 1));
    end
    bound = len * 20 + 50;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len);
    while (!fin && k < bound) begin
      @(negedge clk);
      k++;
      if (abort_after > 0 && hs >= abort_after) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.ram_en, bus.m_valid, bus.m_last} !== 5'b0) begin
          errors++;
          $display("FAIL abort_ctrl: got %b expected 00000",
                   {busy, done, bus.ram_en, bus.m_valid, bus.m_last});
        end
        checks++;
        if (bus.ram_addr !== '0 || bus.m_data !== '0) begin
          errors++;
          $display("FAIL abort_bus: got addr %0h data %0h expected 0 0", bus.ram_addr, bus.m_data);
        end
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        start = poke_start && (k == 2);
        if (poke_start && k == 2) begin
          base_addr = AW'(500); length = (AW + 1)'(3);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_din !== '0) begin
          errors++;
          $display("FAIL ram_tie: got we %b din %0h expected 0 0", bus.ram_we, bus.ram_din);
        end
        if (k == 2 && len > 0) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_run: got %b expected 1", busy);
          end
        end
        if (bus.ram_en === 1'b1) begin
          checks++;
          if (issued - hs >= FD) begin
            errors++;
            $display("FAIL credit: got occupancy %0d expected < %0d", issued - hs, FD);
          end
          checks++;
          if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL extra_read: got read at %0d expected none", bus.ram_addr);
          end else begin
            a = addr_q.pop_front();
            if (bus.ram_addr !== AW'(a)) begin
              errors++;
              $display("FAIL read_addr: got %0d expected %0d", bus.ram_addr, a);
            end
          end
          issued++;
        end
        if (prev_stall) begin
          checks++;
          if (bus.m_valid !== 1'b1 || bus.m_data !== held_data || bus.m_last !== held_last) begin
            errors++;
            $display("FAIL stall_hold: got v%b %0h l%b expected v1 %0h l%b",
                     bus.m_valid, bus.m_data, bus.m_last, held_data, held_last);
          end
        end
        if (bus.m_valid === 1'b1 && first_k < 0) first_k = k;
        bus.m_ready = ($urandom_range(99) < ready_pct);
        prev_stall = 1'b0;
        if (bus.m_valid === 1'b1) begin
          if (bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL extra_beat: got %0h expected no beat", bus.m_data);
            end else begin
              ed = exp_q.pop_front();
              el = (exp_q.size() == 0);
              if (bus.m_data !== ed || bus.m_last !== el) begin
                errors++;
                $display("FAIL beat: got %0h last %b expected %0h last %b",
                         bus.m_data, bus.m_last, ed, el);
              end
              if (el) last_k = k;
            end
            hs++;
          end else begin
            stalls++;
            prev_stall = 1'b1;
            held_data = bus.m_data;
            held_last = bus.m_last;
          end
        end
        if (done_k >= 0) begin
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done %b busy %b expected 0 0", done, busy);
          end
          fin = 1'b1;
        end else if (done === 1'b1) begin
          done_k = k;
        end
      end
    end
    if (!aborted) begin
      checks++;
      if (!fin) begin
        errors++;
        $display("FAIL timeout: got no done within %0d cycles expected done", bound);
      end
      checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
        errors++;
        $display("FAIL missing: got %0d beats %0d reads outstanding expected 0 0",
                 exp_q.size(), addr_q.size());
      end
    end
    start = 1'b0;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bus.ram_en, bus.m_valid, bus.m_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, done, bus.ram_en, bus.m_valid, bus.m_last});
    end
    checks++;
    if (bus.ram_addr !== '0 || bus.m_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %0h data %0h expected 0 0", bus.ram_addr, bus.m_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int f, l, d, s;
    run_transfer(5, 8, 100, 0, 1'b0, f, l, d, s);
    checks++;
    if (f !== 3) begin errors++; $display("FAIL first_latency: got %0d expected 3", f); end
    checks++;
    if (l - f !== 7) begin errors++; $display("FAIL contiguous: got %0d expected 7", l - f); end
    checks++;
    if (d !== l + 1) begin errors++; $display("FAIL done_latency: got %0d expected %0d", d, l + 1); end
  endtask

  task automatic test_wrap();
    int f, l, d, s;
    run_transfer(1020, 6, 100, 0, 1'b0, f, l, d, s);
    checks++;
    if (l - f !== 5) begin errors++; $display("FAIL wrap_span: got %0d expected 5", l - f); end
  endtask

  task automatic test_backpressure();
    int f, l, d, s;
    run_transfer(40, 8, 40, 0, 1'b0, f, l, d, s);
    checks++;
    if (d !== l + 1) begin errors++; $display("FAIL bp_done: got %0d expected %0d", d, l + 1); end
`ifdef RAM_STREAM_READER_PERF_EN
    checks++;
    if (stall_cycles !== 32'(s)) begin
      errors++;
      $display("FAIL stall_count: got %0d expected %0d", stall_cycles, s);
    end
`endif
  endtask

  task automatic test_zero_len();
    int f, l, d, s;
    run_transfer(7, 0, 100, 0, 1'b0, f, l, d, s);
    checks++;
    if (d !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", d); end
    checks++;
    if (f !== -1) begin errors++; $display("FAIL zero_valid: got %0d expected -1", f); end
  endtask

  task automatic test_ignore_start();
    int f, l, d, s;
    run_transfer(100, 4, 100, 0, 1'b1, f, l, d, s);
    checks++;
    if (d !== l + 1) begin errors++; $display("FAIL ignore_done: got %0d expected %0d", d, l + 1); end
  endtask

  task automatic test_full_range();
    int f, l, d, s;
    run_transfer(0, 1024, 100, 0, 1'b0, f, l, d, s);
    checks++;
    if (l - f !== 1023) begin errors++; $display("FAIL full_span: got %0d expected 1023", l - f); end
  endtask

  task automatic test_abort();
    int f, l, d, s;
    run_transfer(200, 10, 100, 3, 1'b0, f, l, d, s);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_transfer(300, 10, 70, 0, 1'b0, f, l, d, s);
    checks++;
    if (d !== l + 1) begin errors++; $display("FAIL post_abort_done: got %0d expected %0d", d, l + 1); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + 32'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_ignore_start();
    test_full_range();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for behav_dual_port_ram. Drives one RAM port, with en, we, addr, din and dout, as a read-only master.
- Streams a contiguous address range out as a valid/ready beat stream with a last-beat marker.
- Absorbs the RAM's fixed 1-cycle read latency and downstream backpressure using a credit-gated output FIFO.
- Used to feed buffered tensors from on-chip RAM into accelerator compute lanes.

Parameters:
- DATA_WIDTH, 32, width of a RAM word and of a stream beat.
- ADDR_WIDTH, 10, RAM address width; RAM depth is 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, output FIFO entries; must be at least 2; 4 sustains 1 beat/cycle.

Ports:
- clk, input, 1, single clock for all logic.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a transfer; accepted only in IDLE.
- base_addr, input, ADDR_WIDTH, first word address; sampled with an accepted start.
- length, input, ADDR_WIDTH+1, word count 0..2^ADDR_WIDTH; sampled with an accepted start.
- busy, output, 1, high whenever state is not IDLE.
- done, output, 1, one-cycle completion pulse.
- ram_en, output, 1, RAM port enable.
- ram_we, output, 1, tied to 0.
- ram_addr, output, ADDR_WIDTH, RAM read address.
- ram_din, output, DATA_WIDTH, tied to 0.
- ram_dout, input, DATA_WIDTH, RAM read data; valid the cycle after ram_en.
- m_valid, output, 1, stream beat valid.
- m_ready, input, 1, downstream ready.
- m_data, output, DATA_WIDTH, beat data.
- m_last, output, 1, marks the final beat of a transfer.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; FIFO empty; counters 0.
  - busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_last=0, m_data=0.
- States and transitions:
  - IDLE to RUN: on start with length>0. Latch base_addr, length; set issue_cnt=length and beat_cnt=length.
  - IDLE to FINISH: on start with length=0. No RAM access, no beats.
  - RUN to FINISH: on the handshake (m_valid && m_ready) of the beat with m_last=1.
  - FINISH to IDLE: after 1 cycle. done=1 only in FINISH.
- Read issue:
  - ram_en=1 in a RUN cycle iff issue_cnt>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is the 1-bit "read issued last cycle" flag.
  - ram_addr increments after each issue and wraps from 2^ADDR_WIDTH-1 to 0.
- Capture: when inflight=1, ram_dout is pushed into the FIFO at the next edge. Credit gating guarantees the FIFO never overflows and no RAM data is dropped.
- Stream:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_last=1 iff beat_cnt==1 while m_valid=1.
  - m_data/m_last hold stable while m_valid && !m_ready.
  - Pop and beat_cnt decrement on handshake; a push and a pop in the same cycle are both honoured.
- Latency: start accepted in cycle 0, first ram_en in cycle 1, ram_dout valid in cycle 2, first m_valid in cycle 3.
- Throughput: with m_ready held high and FIFO_DEPTH>=4, one beat per cycle until completion.
- done rises in the cycle after the last handshake.
- Boundaries:
  - start while busy is ignored; latched values are unchanged.
  - length=2^ADDR_WIDTH reads every word exactly once, starting at base_addr and wrapping.
  - rst_n asserted mid-transfer aborts immediately: FIFO is flushed, in-flight data is discarded, no done pulse.

Optional Feature:
- Macro RAM_STREAM_READER_PERF_EN.
- Defined:
  - Adds output port stall_cycles, 32 bits.
  - Counts cycles with m_valid && !m_ready.
  - Cleared by rst_n and by an accepted start; saturates at 2^32-1; holds its value in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Preload mem[i]=i+0x100. start, base=5, length=8, m_ready=1 -> beats 0x105..0x10C, m_valid first high in cycle 3, contiguous, m_last on 0x10C, done 1 cycle later.
- base=1020, length=6, ADDR_WIDTH=10 -> ram_addr 1020,1021,1022,1023,0,1 and data matches; no duplicates.
- length=8, m_ready random 40% -> all 8 beats in order, data stable during stalls, ram_en never issued with fifo_count+inflight>=FIFO_DEPTH. With the macro defined, stall_cycles equals the counted stalls.
- length=0 -> done pulse in the cycle after start, ram_en never asserted, m_valid never asserted; start during busy ignored.
- length=1024 from base=0 -> 1024 beats, 1023 cycles between first and last beat with m_ready=1.
- Assert rst_n=0 after 3 beats of a length-10 transfer -> all outputs 0 asynchronously. A fresh start afterwards produces a correct, complete stream.
